// File: rtl/conv_sa_ctrl.sv
// Operand pacing, reset-bubble insertion and row reset/flush sequencing
// for the SA_R x SA_C output-stationary conv systolic array.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_INIT   | post-reset zero feed with one reset pulse to clear stale P regs
// S_IDLE   | waiting for start
// S_FEED   | popping K operands, zero-filling on src_vld stalls
// S_BUBBLE | one zero slot that launches the row reset wave
// S_PAD    | zero slots stretching the period to at least 2*SA_R
// S_DRAIN  | zero feed until the last flush has left the bottom row
// S_DONE   | one-cycle done pulse
module conv_sa_ctrl #(
  parameter int SA_R   = 16,
  parameter int SA_C   = 16,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_vec_len,
  input  logic [LEN_W-1:0] cfg_n_vec,
  input  logic             src_vld,
  output logic             feed_rd,
  output logic             feed_zero,
  output logic [SA_R-1:0]  sa_rst,
  output logic [SA_R-1:0]  sa_flush,
  output logic             res_vld,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  localparam int INIT_LEN  = SA_R + SA_C + RD_LAT + 3;
  localparam int DRAIN_LEN = RD_LAT + 2*SA_R + SA_C;
  localparam int MIN_PER   = 2*SA_R;
  localparam int INIT_W    = $clog2(INIT_LEN + 1);
  localparam int DRN_W     = $clog2(DRAIN_LEN + 1);
  localparam int PAD_W     = $clog2(MIN_PER + 1);
  localparam int FL_W      = $clog2(SA_R + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_FEED, S_BUBBLE, S_PAD, S_DRAIN, S_DONE
  } state_t;

  state_t             state;
  logic [INIT_W-1:0]  init_cnt;
  logic [LEN_W-1:0]   k_len;
  logic [LEN_W-1:0]   k_rem;
  logic [LEN_W-1:0]   vec_rem;
  logic [PAD_W-1:0]   pad_len;
  logic [PAD_W-1:0]   pad_rem;
  logic [DRN_W-1:0]   drn_cnt;
  logic               in_feed;
  logic               zero_st;
  logic               bub;
  logic [PAD_W-1:0]   pad_len_c;
  logic [RD_LAT:0]    dly;
  logic [FL_W-1:0]    fl_cnt;

  always_comb begin
    pad_len_c = '0;
    if (32'(cfg_vec_len) < MIN_PER - 1)
      pad_len_c = PAD_W'(MIN_PER - 1 - 32'(cfg_vec_len));
  end

  // Pop/zero must follow src_vld in the same cycle, so only this gating is combinational.
  assign feed_rd   = in_feed & src_vld;
  assign feed_zero = zero_st | (in_feed & ~src_vld);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_INIT;
      init_cnt <= INIT_W'(INIT_LEN);
      k_len    <= '0;
      k_rem    <= '0;
      vec_rem  <= '0;
      pad_len  <= '0;
      pad_rem  <= '0;
      drn_cnt  <= '0;
      in_feed  <= 1'b0;
      zero_st  <= 1'b0;
      bub      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      bub  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_cnt != '0) begin
            init_cnt <= init_cnt - 1'b1;
            busy     <= 1'b1;
            zero_st  <= 1'b1;
            bub      <= (init_cnt == INIT_W'(INIT_LEN));
          end else begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            zero_st <= 1'b0;
          end
        end
        S_IDLE: begin
          if (start) begin
            k_len   <= cfg_vec_len;
            k_rem   <= cfg_vec_len;
            vec_rem <= cfg_n_vec;
            pad_len <= pad_len_c;
            busy    <= 1'b1;
            if (cfg_n_vec == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (cfg_vec_len == '0) begin
              state   <= S_BUBBLE;
              zero_st <= 1'b1;
              bub     <= 1'b1;
            end else begin
              state   <= S_FEED;
              in_feed <= 1'b1;
            end
          end
        end
        S_FEED: begin
          if (src_vld) begin
            if (k_rem == LEN_W'(1)) begin
              state   <= S_BUBBLE;
              in_feed <= 1'b0;
              zero_st <= 1'b1;
              bub     <= 1'b1;
            end else begin
              k_rem <= k_rem - 1'b1;
            end
          end
        end
        S_BUBBLE: begin
          k_rem <= k_len;
          if (vec_rem == LEN_W'(1)) begin
            state   <= S_DRAIN;
            drn_cnt <= DRN_W'(DRAIN_LEN);
          end else begin
            vec_rem <= vec_rem - 1'b1;
            // pad_len==0 implies K >= 2*SA_R-1, so FEED always has work here
            if (pad_len != '0) begin
              state   <= S_PAD;
              pad_rem <= pad_len;
            end else begin
              state   <= S_FEED;
              zero_st <= 1'b0;
              in_feed <= 1'b1;
            end
          end
        end
        S_PAD: begin
          if (pad_rem == PAD_W'(1)) begin
            if (k_len == '0) begin
              state <= S_BUBBLE;
              bub   <= 1'b1;
            end else begin
              state   <= S_FEED;
              zero_st <= 1'b0;
              in_feed <= 1'b1;
            end
          end else begin
            pad_rem <= pad_rem - 1'b1;
          end
        end
        S_DRAIN: begin
          if (drn_cnt == '0) begin
            state   <= S_DONE;
            zero_st <= 1'b0;
            done    <= 1'b1;
          end else begin
            drn_cnt <= drn_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_INIT;
          init_cnt <= INIT_W'(INIT_LEN);
        end
      endcase
    end
  end

  // Bubble -> row-0 reset after operand latency plus PE M-pipeline, then one row per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dly      <= '0;
      sa_rst   <= '0;
      sa_flush <= '0;
      res_vld  <= 1'b0;
      res_last <= 1'b0;
      fl_cnt   <= '0;
    end else begin
      dly[0] <= bub;
      for (int i = 1; i <= RD_LAT; i++) dly[i] <= dly[i-1];
      sa_rst[0] <= dly[RD_LAT];
      for (int r = 1; r < SA_R; r++) sa_rst[r] <= sa_rst[r-1];

      // The init reset wave only clears accumulators; it never produces results.
      if (sa_rst[SA_R-1] && state != S_INIT) begin
        fl_cnt   <= FL_W'(SA_R - 1);
        sa_flush <= '1;
        res_vld  <= 1'b1;
      end else if (fl_cnt != '0) begin
        fl_cnt <= fl_cnt - 1'b1;
      end else begin
        sa_flush <= '0;
        res_vld  <= 1'b0;
      end

      res_last <= (state == S_DRAIN) && (drn_cnt == DRN_W'(SA_C + 1));
    end
  end

endmodule

// File: tb/tb_conv_sa_ctrl.sv
// Randomized bench for conv_sa_ctrl: expected per-cycle outputs are built
// from the bubble/reset/flush timing rules as a cycle-indexed timeline.
module tb_conv_sa_ctrl;

  localparam int SA_R     = 4;
  localparam int SA_C     = 3;
  localparam int LEN_W    = 8;
  localparam int RD_LAT   = 1;
  localparam int D        = RD_LAT + 2;
  localparam int INIT_CYC = SA_R + SA_C + RD_LAT + 3;
  localparam int MAXC     = 1024;
  localparam int VW       = 6 + 2*SA_R;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_vec_len = '0;
  logic [LEN_W-1:0] cfg_n_vec = '0;
  logic             src_vld = 1'b0;
  logic             feed_rd, feed_zero, res_vld, res_last, busy, done;
  logic [SA_R-1:0]  sa_rst, sa_flush;

  conv_sa_ctrl #(.SA_R(SA_R), .SA_C(SA_C), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_vec_len(cfg_vec_len),
    .cfg_n_vec(cfg_n_vec), .src_vld(src_vld), .feed_rd(feed_rd),
    .feed_zero(feed_zero), .sa_rst(sa_rst), .sa_flush(sa_flush),
    .res_vld(res_vld), .res_last(res_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit              srcv [MAXC];
  bit              stv  [MAXC];
  bit              e_busy [MAXC];
  bit              e_done [MAXC];
  bit              e_rd   [MAXC];
  bit              e_fz   [MAXC];
  bit              e_rv   [MAXC];
  bit              e_rl   [MAXC];
  logic [SA_R-1:0] e_rst  [MAXC];
  logic [SA_R-1:0] e_fl   [MAXC];

  int rd_cnt, rv_cnt, done_cnt, ovl_cnt, both_cnt;
  int rst_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {busy, done, feed_rd, feed_zero, res_vld, res_last, sa_flush, sa_rst};
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int i);
    return {e_busy[i], e_done[i], e_rd[i], e_fz[i], e_rv[i], e_rl[i], e_fl[i], e_rst[i]};
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_fz[i] = 0;
      e_rv[i] = 0; e_rl[i] = 0; e_rst[i] = '0; e_fl[i] = '0; stv[i] = 0;
    end
  endtask

  task automatic fill_src(input int stall_pct);
    for (int i = 0; i < MAXC; i++) srcv[i] = ($urandom_range(0, 99) >= stall_pct);
  endtask

  task automatic reset_aggr();
    rd_cnt = 0; rv_cnt = 0; done_cnt = 0; ovl_cnt = 0; both_cnt = 0;
    rst_q.delete();
  endtask

  // One row-reset wave starting at t0; optionally with its flush/result window.
  task automatic add_wave(input int t0, input bit with_flush);
    for (int r = 0; r < SA_R; r++) e_rst[t0 + r][r] = 1'b1;
    if (with_flush)
      for (int j = SA_R; j < 2*SA_R; j++) begin
        e_fl[t0 + j] = '1;
        e_rv[t0 + j] = 1'b1;
      end
  endtask

  task automatic build_init(output int len);
    clear_exp();
    for (int i = 0; i < INIT_CYC; i++) begin
      e_busy[i] = 1'b1;
      e_fz[i]   = 1'b1;
    end
    add_wave(D, 1'b0);
    stv[2] = 1'b1;
    stv[INIT_CYC - 1] = 1'b1;
    len = INIT_CYC + 3;
  endtask

  // Index 0 is the start cycle; the job begins at index 1.
  task automatic build_job(input int k, input int nv, output int len);
    int cur, pad, nb, t0, x, got;
    clear_exp();
    stv[0] = 1'b1;
    if (nv == 0) begin
      e_busy[1] = 1'b1;
      e_done[1] = 1'b1;
      stv[1]    = 1'b1;
      len = 4;
      return;
    end
    pad = (k + 1 >= 2*SA_R) ? 0 : 2*SA_R - (k + 1);
    cur = 1;
    t0  = 0;
    for (int v = 0; v < nv; v++) begin
      if (v > 0)
        for (int p = 0; p < pad; p++) begin
          e_fz[cur] = 1'b1;
          cur++;
        end
      got = 0;
      while (got < k && cur < MAXC - 64) begin
        if (srcv[cur]) begin
          e_rd[cur] = 1'b1;
          got++;
        end else begin
          e_fz[cur] = 1'b1;
        end
        cur++;
      end
      e_fz[cur] = 1'b1;
      nb = cur;
      cur++;
      t0 = nb + D;
      add_wave(t0, 1'b1);
    end
    x = t0 + 2*SA_R - 1 + SA_C;
    for (int c = cur; c <= x; c++) e_fz[c] = 1'b1;
    e_rl[t0 + 2*SA_R - 1] = 1'b1;
    for (int c = 1; c <= x + 1; c++) begin
      e_busy[c] = 1'b1;
      stv[c] = ($urandom_range(0, 7) == 0);
    end
    e_done[x + 1] = 1'b1;
    stv[x + 1] = 1'b1;
    len = x + 4;
  endtask

  task automatic run_window(input int n, input string tag, input int k, input int nv);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      src_vld = srcv[i];
      start   = stv[i];
      if (i == 0) begin
        cfg_vec_len = LEN_W'(k);
        cfg_n_vec   = LEN_W'(nv);
      end else begin
        cfg_vec_len = LEN_W'($urandom);
        cfg_n_vec   = LEN_W'($urandom);
      end
      #1;
      chk($sformatf("%s@%0d", tag, i), 32'(obs_vec()), 32'(exp_vec(i)));
      rd_cnt   += int'(feed_rd);
      rv_cnt   += int'(res_vld);
      done_cnt += int'(done);
      if (res_vld && sa_rst[0]) ovl_cnt++;
      if (feed_rd && feed_zero) both_cnt++;
      if (sa_rst[0]) rst_q.push_back(i);
    end
    start = 1'b0;
  endtask

  task automatic do_init();
    int len;
    build_init(len);
    fill_src(50);
    reset_aggr();
    run_window(len, "init", 0, 0);
    chk("init_rv", rv_cnt, 0);
    chk("init_rd", rd_cnt, 0);
    chk("init_rst_waves", rst_q.size(), 1);
  endtask

  task automatic do_job(input int k, input int nv, input string tag, input int abort_at);
    int len;
    build_job(k, nv, len);
    reset_aggr();
    if (abort_at > 0) begin
      run_window(abort_at + 1, tag, k, nv);
      return;
    end
    run_window(len, tag, k, nv);
    chk({tag, "_rd"}, rd_cnt, k*nv);
    chk({tag, "_rv"}, rv_cnt, nv*SA_R);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_ovl"}, ovl_cnt, 0);
    chk({tag, "_rdzero"}, both_cnt, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(obs_vec()), 0);
    @(negedge clk);
    rstn = 1'b1;
    do_init();

    fill_src(0);
    do_job(9, 2, "k9n2", 0);
    if (rst_q.size() == 2) chk("k9n2_period", rst_q[1] - rst_q[0], 10);
    else chk("k9n2_nbub", rst_q.size(), 2);
    chk("k9n2_first_rst", (rst_q.size() > 0) ? rst_q[0] : -1, 10 + D);

    fill_src(0);
    do_job(3, 3, "pad", 0);
    chk("pad_nbub", rst_q.size(), 3);
    if (rst_q.size() == 3) begin
      chk("pad_period0", rst_q[1] - rst_q[0], 8);
      chk("pad_period1", rst_q[2] - rst_q[1], 8);
    end

    fill_src(0);
    for (int i = 4; i < 9; i++) srcv[i] = 1'b0;
    do_job(9, 1, "stall", 0);
    chk("stall_first_rst", (rst_q.size() > 0) ? rst_q[0] : -1, 1 + 9 + 5 + D);

    fill_src(20);
    do_job(5, 0, "n0", 0);

    fill_src(30);
    do_job(0, 2, "k0", 0);

    for (int j = 0; j < 8; j++) begin
      fill_src($urandom_range(0, 40));
      do_job($urandom_range(0, 20), $urandom_range(0, 4), $sformatf("rnd%0d", j), 0);
    end

    fill_src(0);
    do_job(9, 2, "abort", 6);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst", 32'(obs_vec()), 0);
    repeat (2) @(negedge clk);
    #1;
    chk("async_rst_hold", 32'(obs_vec()), 0);
    @(negedge clk);
    rstn = 1'b1;
    do_init();
    fill_src(0);
    do_job(9, 2, "post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
